// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control sequencer: holds PC and IR, and steps datapath_legv8
// through fetch, decode, execute, memory and branch cycles via a combinational control word.
module legv8_control_unit #(
    parameter logic [63:0] PC_RESET = 64'd0,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic [63:0]       f,
    input  logic [3:0]        stat,
    output logic [63:0]       imem_addr,
    output logic [4:0]        DA,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        FS,
    output logic              W_reg,
    output logic              W_ram,
    output logic              c_out,
    output logic              B_sel,
    output logic              B_en,
    output logic              ram_en,
    output logic              alu_en,
    output logic              D_en,
    output logic [63:0]       k,
    output logic [ADDR_W-1:0] addr,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_ADDR,
        S_MEM_LD,
        S_MEM_ST,
        S_HALT
    } state_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [63:0]       r_pc;
    logic [63:0]       w_pc_nxt;
    logic [31:0]       r_ir;
    logic [31:0]       w_ir_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_illegal;
    logic              w_illegal_nxt;

    // Opcode decode from the latched instruction
    logic w_is_add, w_is_sub, w_is_and, w_is_orr, w_is_eor;
    logic w_is_addi, w_is_subi, w_is_ldur, w_is_stur, w_is_b, w_is_cbz, w_is_hlt;
    logic w_is_rtype, w_is_itype;

    assign w_is_add   = (r_ir[31:21] == 11'b10001011000);
    assign w_is_sub   = (r_ir[31:21] == 11'b11001011000);
    assign w_is_and   = (r_ir[31:21] == 11'b10001010000);
    assign w_is_orr   = (r_ir[31:21] == 11'b10101010000);
    assign w_is_eor   = (r_ir[31:21] == 11'b11001010000);
    assign w_is_addi  = (r_ir[31:22] == 10'b1001000100);
    assign w_is_subi  = (r_ir[31:22] == 10'b1101000100);
    assign w_is_ldur  = (r_ir[31:21] == 11'b11111000010);
    assign w_is_stur  = (r_ir[31:21] == 11'b11111000000);
    assign w_is_b     = (r_ir[31:26] == 6'b000101);
    assign w_is_cbz   = (r_ir[31:24] == 8'b10110100);
    assign w_is_hlt   = (r_ir[31:21] == 11'b11010100010);
    assign w_is_rtype = w_is_add | w_is_sub | w_is_and | w_is_orr | w_is_eor;
    assign w_is_itype = w_is_addi | w_is_subi;

    // Branch and memory offsets; PC arithmetic wraps modulo 2^64
    logic [63:0] w_br_off;
    logic [63:0] w_cb_off;
    logic [63:0] w_imm9;
    logic [63:0] w_imm12;

    assign w_br_off = {{36{r_ir[25]}}, r_ir[25:0], 2'b00};
    assign w_cb_off = {{43{r_ir[23]}}, r_ir[23:5], 2'b00};
    assign w_imm9   = {{55{r_ir[20]}}, r_ir[20:12]};
    assign w_imm12  = {52'd0, r_ir[21:10]};

    logic w_unused;
    assign w_unused = ^{f[63:ADDR_W], stat[3:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= PC_RESET;
            r_ir      <= 32'd0;
            r_addr    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_addr    <= w_addr_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_addr_nxt    = r_addr;
        w_illegal_nxt = r_illegal;
        DA     = 5'd0;
        SA     = 5'd0;
        SB     = 5'd0;
        FS     = FS_AND;
        W_reg  = 1'b0;
        W_ram  = 1'b0;
        c_out  = 1'b0;
        B_sel  = 1'b0;
        B_en   = 1'b0;
        ram_en = 1'b0;
        alu_en = 1'b0;
        D_en   = 1'b0;
        k      = 64'd0;

        case (r_state)
            S_FETCH: begin
                w_ir_nxt    = instr;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_rtype || w_is_itype || w_is_b || w_is_cbz) begin
                    w_state_nxt = S_EXEC;
                end else if (w_is_ldur || w_is_stur) begin
                    w_state_nxt = S_MEM_ADDR;
                end else if (w_is_hlt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt   = S_HALT;
                    w_illegal_nxt = 1'b1;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = r_pc + 64'd4;
                if (w_is_rtype || w_is_itype) begin
                    SA     = r_ir[9:5];
                    SB     = r_ir[20:16];
                    DA     = r_ir[4:0];
                    alu_en = 1'b1;
                    W_reg  = 1'b1;
                    if (w_is_itype) begin
                        SB    = 5'd0;
                        B_sel = 1'b1;
                        k     = w_imm12;
                    end
                    if (w_is_add || w_is_addi) begin
                        FS = FS_ADD;
                    end else if (w_is_sub || w_is_subi) begin
                        FS    = FS_SUB;
                        c_out = 1'b1;
                    end else if (w_is_orr) begin
                        FS = FS_ORR;
                    end else if (w_is_eor) begin
                        FS = FS_EOR;
                    end else begin
                        FS = FS_AND;
                    end
                end else if (w_is_b) begin
                    w_pc_nxt = r_pc + w_br_off;
                end else if (w_is_cbz) begin
                    // Rt + 0 through the ALU; Z flag decides the branch this cycle
                    SA    = r_ir[4:0];
                    B_sel = 1'b1;
                    FS    = FS_ADD;
                    if (stat[0]) begin
                        w_pc_nxt = r_pc + w_cb_off;
                    end
                end
            end
            S_MEM_ADDR: begin
                SA         = r_ir[9:5];
                B_sel      = 1'b1;
                k          = w_imm9;
                FS         = FS_ADD;
                w_addr_nxt = f[ADDR_W-1:0];
                w_state_nxt = w_is_ldur ? S_MEM_LD : S_MEM_ST;
            end
            S_MEM_LD: begin
                ram_en      = 1'b1;
                W_reg       = 1'b1;
                DA          = r_ir[4:0];
                w_pc_nxt    = r_pc + 64'd4;
                w_state_nxt = S_FETCH;
            end
            S_MEM_ST: begin
                SB          = r_ir[4:0];
                B_en        = 1'b1;
                W_ram       = 1'b1;
                w_pc_nxt    = r_pc + 64'd4;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign addr      = r_addr;
    assign illegal   = r_illegal;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed-vector bench for legv8_control_unit: each task drives one instruction
// sequence and checks the control word, PC, address and status flags cycle by cycle.
module tb_legv8_control_unit;

    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic [31:0]       instr;
    logic [63:0]       f;
    logic [3:0]        stat;
    logic [63:0]       imem_addr;
    logic [4:0]        DA, SA, SB, FS;
    logic              W_reg, W_ram, c_out, B_sel, B_en, ram_en, alu_en, D_en;
    logic [63:0]       k;
    logic [ADDR_W-1:0] addr;
    logic              halted;
    logic              illegal;

    int total = 0;
    int bad   = 0;

    // {DA, SA, SB, FS, W_reg, W_ram, c_out, B_sel, B_en, ram_en, alu_en, D_en}
    logic [27:0] ctl;
    assign ctl = {DA, SA, SB, FS, W_reg, W_ram, c_out, B_sel, B_en, ram_en, alu_en, D_en};

    legv8_control_unit #(
        .PC_RESET (64'd0),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .f         (f),
        .stat      (stat),
        .imem_addr (imem_addr),
        .DA        (DA),
        .SA        (SA),
        .SB        (SB),
        .FS        (FS),
        .W_reg     (W_reg),
        .W_ram     (W_ram),
        .c_out     (c_out),
        .B_sel     (B_sel),
        .B_en      (B_en),
        .ram_en    (ram_en),
        .alu_en    (alu_en),
        .D_en      (D_en),
        .k         (k),
        .addr      (addr),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        instr = 32'hCB020023;
        f     = '1;
        stat  = 4'hF;
        tick();
        tick();
        total++;
        if (ctl !== 28'd0 || k !== 64'd0) begin
            bad++;
            $display("FAIL reset_ctl: got ctl=%h k=%h want 0", ctl, k);
        end
        total++;
        if ({imem_addr, addr, halted, illegal} !== {64'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got pc=%h addr=%h halted=%b illegal=%b want zeros",
                     imem_addr, addr, halted, illegal);
        end
        rst  = 1'b0;
        f    = 64'd0;
        stat = 4'd0;
    endtask

    task automatic test_branch_wrap();
        instr = 32'h17FFFFFF;   // B #-1 from pc 0
        tick();
        total++;
        if (ctl !== 28'd0) begin
            bad++;
            $display("FAIL decode_quiet: got ctl=%h want 0", ctl);
        end
        tick();
        total++;
        if (ctl !== 28'd0 || k !== 64'd0) begin
            bad++;
            $display("FAIL b_exec_quiet: got ctl=%h k=%h want 0", ctl, k);
        end
        tick();
        total++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++;
            $display("FAIL b_neg_wrap: got pc=%h want fffffffffffffffc", imem_addr);
        end
        instr = 32'h14000001;   // B #1 wraps back to 0
        tick();
        tick();
        tick();
        total++;
        if (imem_addr !== 64'd0) begin
            bad++;
            $display("FAIL b_pos_wrap: got pc=%h want 0", imem_addr);
        end
    endtask

    task automatic test_addi();
        instr = 32'h910017E1;   // ADDI X1,X31,#5
        tick();
        tick();
        total++;
        if (ctl !== {5'd1, 5'd31, 5'd0, 5'b01000, 8'b1001_0010}) begin
            bad++;
            $display("FAIL addi_ctl: got ctl=%h want %h", ctl,
                     {5'd1, 5'd31, 5'd0, 5'b01000, 8'b1001_0010});
        end
        total++;
        if (k !== 64'd5) begin
            bad++;
            $display("FAIL addi_k: got k=%h want 5", k);
        end
        tick();
        total++;
        if (imem_addr !== 64'd4) begin
            bad++;
            $display("FAIL addi_pc: got pc=%h want 4", imem_addr);
        end
    endtask

    task automatic test_sub();
        instr = 32'hCB020023;   // SUB X3,X1,X2
        tick();
        tick();
        total++;
        if (ctl !== {5'd3, 5'd1, 5'd2, 5'b01001, 8'b1010_0010} || k !== 64'd0) begin
            bad++;
            $display("FAIL sub_ctl: got ctl=%h k=%h want %h k=0", ctl, k,
                     {5'd3, 5'd1, 5'd2, 5'b01001, 8'b1010_0010});
        end
        tick();
        total++;
        if (imem_addr !== 64'd8) begin
            bad++;
            $display("FAIL sub_pc: got pc=%h want 8", imem_addr);
        end
    endtask

    task automatic test_ldur();
        instr = 32'hF85FF025;   // LDUR X5,[X1,#-1]
        tick();
        tick();
        total++;
        if (ctl !== {5'd0, 5'd1, 5'd0, 5'b01000, 8'b0001_0000} || k !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL ldur_addr_ctl: got ctl=%h k=%h want %h k=ffffffffffffffff", ctl, k,
                     {5'd0, 5'd1, 5'd0, 5'b01000, 8'b0001_0000});
        end
        f = 64'h1234;
        tick();
        f = 64'd0;
        total++;
        if (addr !== 8'h34 || imem_addr !== 64'd8) begin
            bad++;
            $display("FAIL ldur_addr: got addr=%h pc=%h want addr=34 pc=8", addr, imem_addr);
        end
        total++;
        if (ctl !== {5'd5, 5'd0, 5'd0, 5'b00000, 8'b1000_0100}) begin
            bad++;
            $display("FAIL ldur_ld_ctl: got ctl=%h want %h", ctl,
                     {5'd5, 5'd0, 5'd0, 5'b00000, 8'b1000_0100});
        end
        tick();
        total++;
        if (imem_addr !== 64'hC) begin
            bad++;
            $display("FAIL ldur_pc: got pc=%h want c", imem_addr);
        end
    endtask

    task automatic test_stur();
        instr = 32'hF8008022;   // STUR X2,[X1,#8]
        tick();
        tick();
        total++;
        if (ctl !== {5'd0, 5'd1, 5'd0, 5'b01000, 8'b0001_0000} || k !== 64'd8) begin
            bad++;
            $display("FAIL stur_addr_ctl: got ctl=%h k=%h want %h k=8", ctl, k,
                     {5'd0, 5'd1, 5'd0, 5'b01000, 8'b0001_0000});
        end
        f = 64'h10;
        tick();
        f = 64'd0;
        total++;
        if (addr !== 8'h10) begin
            bad++;
            $display("FAIL stur_addr: got addr=%h want 10", addr);
        end
        total++;
        if (ctl !== {5'd0, 5'd0, 5'd2, 5'b00000, 8'b0100_1000}) begin
            bad++;
            $display("FAIL stur_st_ctl: got ctl=%h want %h", ctl,
                     {5'd0, 5'd0, 5'd2, 5'b00000, 8'b0100_1000});
        end
        total++;
        if ($countones({B_en, ram_en, alu_en, D_en}) != 1) begin
            bad++;
            $display("FAIL stur_bus_onehot: got enables=%b want exactly one",
                     {B_en, ram_en, alu_en, D_en});
        end
        tick();
        total++;
        if (imem_addr !== 64'h10) begin
            bad++;
            $display("FAIL stur_pc: got pc=%h want 10", imem_addr);
        end
    endtask

    task automatic test_cbz();
        instr = 32'h14000004;   // B #4: 0x10 -> 0x20
        tick();
        tick();
        tick();
        total++;
        if (imem_addr !== 64'h20) begin
            bad++;
            $display("FAIL b_fwd_pc: got pc=%h want 20", imem_addr);
        end
        instr = 32'hB4FFFFC4;   // CBZ X4,#-2
        tick();
        tick();
        total++;
        if (ctl !== {5'd0, 5'd4, 5'd0, 5'b01000, 8'b0001_0000} || k !== 64'd0) begin
            bad++;
            $display("FAIL cbz_ctl: got ctl=%h k=%h want %h k=0", ctl, k,
                     {5'd0, 5'd4, 5'd0, 5'b01000, 8'b0001_0000});
        end
        stat = 4'b0001;
        tick();
        stat = 4'b0000;
        total++;
        if (imem_addr !== 64'h18) begin
            bad++;
            $display("FAIL cbz_taken_pc: got pc=%h want 18", imem_addr);
        end
        instr = 32'h14000002;   // B #2: 0x18 -> 0x20
        tick();
        tick();
        tick();
        instr = 32'hB4FFFFC4;
        tick();
        tick();
        stat = 4'b1110;         // Z clear, other flags set
        tick();
        stat = 4'b0000;
        total++;
        if (imem_addr !== 64'h24) begin
            bad++;
            $display("FAIL cbz_not_taken_pc: got pc=%h want 24", imem_addr);
        end
    endtask

    task automatic test_illegal();
        instr = 32'hFFFFFFFF;
        tick();
        tick();
        total++;
        if ({halted, illegal} !== 2'b11 || ctl !== 28'd0) begin
            bad++;
            $display("FAIL illegal_halt: got halted=%b illegal=%b ctl=%h want 1 1 0",
                     halted, illegal, ctl);
        end
        for (int i = 0; i < 10; i++) begin
            instr = $urandom;
            stat  = 4'($urandom);
            tick();
            total++;
            if (imem_addr !== 64'h24 || halted !== 1'b1 || ctl !== 28'd0) begin
                bad++;
                $display("FAIL halt_frozen[%0d]: got pc=%h halted=%b ctl=%h want pc=24 halted=1 ctl=0",
                         i, imem_addr, halted, ctl);
            end
        end
        stat = 4'd0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        total++;
        if ({halted, illegal} !== 2'b00 || imem_addr !== 64'd0) begin
            bad++;
            $display("FAIL illegal_clear: got halted=%b illegal=%b pc=%h want 0 0 0",
                     halted, illegal, imem_addr);
        end
    endtask

    task automatic test_hlt();
        instr = 32'hD4400000;   // HLT
        tick();
        tick();
        total++;
        if ({halted, illegal} !== 2'b10) begin
            bad++;
            $display("FAIL hlt_flags: got halted=%b illegal=%b want 1 0", halted, illegal);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL hlt_clear: got halted=%b want 0", halted);
        end
    endtask

    task automatic test_reset_mid();
        instr = 32'h910017E1;
        tick();
        tick();
        tick();                 // pc = 4
        instr = 32'hCB020023;
        tick();                 // DECODE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (imem_addr !== 64'd0 || ctl !== 28'd0) begin
            bad++;
            $display("FAIL reset_mid: got pc=%h ctl=%h want 0 0", imem_addr, ctl);
        end
        instr = 32'h910017E1;
        tick();
        tick();
        total++;
        if (ctl !== {5'd1, 5'd31, 5'd0, 5'b01000, 8'b1001_0010}) begin
            bad++;
            $display("FAIL reset_mid_resume: got ctl=%h want %h", ctl,
                     {5'd1, 5'd31, 5'd0, 5'b01000, 8'b1001_0010});
        end
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'd0;
        f     = 64'd0;
        stat  = 4'd0;
        test_reset();
        test_branch_wrap();
        test_addi();
        test_sub();
        test_ldur();
        test_stur();
        test_cbz();
        test_illegal();
        test_hlt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle LEGv8 control sequencer that produces the control word consumed by datapath_legv8: DA, SA, SB, FS, W_reg, W_ram, c_out, B_sel, B_en, ram_en, alu_en, D_en, k and addr.
- Holds the PC, fetches a 32-bit instruction, decodes it, and steps the datapath through execute, memory and branch cycles.
- Reads back the datapath's f and stat to form RAM addresses and resolve CBZ.

Parameters:
- PC_RESET, 64'd0, PC value loaded on reset.
- ADDR_W, 8, RAM address width; must match datapath addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word at imem_addr, valid combinationally.
- f  in  64  datapath ALU result.
- stat  in  4  datapath ALU flags {V,C,N,Z}; Z = stat[0]; combinationally valid in the same cycle.
- imem_addr  out  64  PC.
- DA, SA, SB  out  5 each  destination and source register selects.
- FS  out  5  ALU function select.
- W_reg  out  1  regfile write.
- W_ram  out  1  RAM write.
- c_out  out  1  ALU carry-in.
- B_sel  out  1  ALU B operand: 1 = k, 0 = reg SB.
- B_en  out  1  drive reg B onto bus.
- ram_en  out  1  drive RAM onto bus.
- alu_en  out  1  drive ALU onto bus.
- D_en  out  1  drive k onto bus.
- k  out  64  constant/immediate.
- addr  out  ADDR_W  registered RAM address.
- halted  out  1  core stopped.
- illegal  out  1  stop was caused by an undefined opcode.

Behaviour:
- Registers: state, pc, IR[31:0], addr, illegal. All control outputs are combinational from state and IR.
- Bus-enable rule: at most one of B_en, ram_en, alu_en, D_en is high in any cycle.
- FS encoding: FS[4:2] selects the operation: 000 AND, 001 ORR, 010 ADD, 011 EOR. FS[1] inverts A, FS[0] inverts B.
  - ADD = 01000, c_out = 0.
  - SUB = 01001, c_out = 1.
- Defaults in every state unless overridden: all strobes 0, DA = SA = SB = 0, FS = 0, k = 0, c_out = 0, B_sel = 0.
- Reset (synchronous, active-high): state = FETCH, pc = PC_RESET, IR = 0, addr = 0, illegal = 0. Outputs are therefore at their defaults.
- rst asserted in any state, including mid-instruction or HALT, aborts the instruction with no further writes.
- States: FETCH, DECODE, EXEC, MEM_ADDR, MEM_LD, MEM_ST, HALT.
- FETCH: imem_addr = pc; IR <= instr; go to DECODE.
- DECODE (no strobes):
  - R-type, I-type, B, CBZ -> EXEC.
  - LDUR, STUR -> MEM_ADDR.
  - HLT (IR[31:21] = 11010100010) -> HALT.
  - Anything else -> HALT with illegal <= 1.
- Opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000 (IR[31:21]).
  - ADDI 1001000100, SUBI 1101000100 (IR[31:22]).
  - LDUR 11111000010, STUR 11111000000 (IR[31:21]).
  - B 000101 (IR[31:26]).
  - CBZ 10110100 (IR[31:24]).
- EXEC, R-type: SA = Rn [9:5], SB = Rm [20:16], DA = Rd [4:0], B_sel = 0, FS/c_out per op, alu_en = 1, W_reg = 1; pc <= pc + 4.
- EXEC, I-type: as R-type but B_sel = 1, k = zero-extended imm12 [21:10].
- EXEC, B: no strobes; pc <= pc + (sign-extended imm26 << 2).
- EXEC, CBZ: SA = Rt [4:0], B_sel = 1, k = 0, FS = ADD.
  - If stat[0] = 1: pc <= pc + (sign-extended imm19 [23:5] << 2).
  - Else: pc <= pc + 4.
  - No register write.
- MEM_ADDR: SA = Rn, B_sel = 1, k = sign-extended imm9 [20:12], FS = ADD; addr <= f[ADDR_W-1:0]. LDUR -> MEM_LD, STUR -> MEM_ST.
- MEM_LD: ram_en = 1, W_reg = 1, DA = Rt; pc <= pc + 4.
- MEM_ST: SB = Rt, B_en = 1, W_ram = 1; pc <= pc + 4.
- Return path: EXEC, MEM_LD and MEM_ST all return to FETCH.
- Latency: ALU ops, B and CBZ take 3 cycles; LDUR and STUR take 4.
- PC arithmetic is modulo 2^64 and wraps silently. Negative offsets follow two's complement.
- HALT: halted = 1, outputs at defaults, pc frozen; leaves only on rst.
- Register 31 is passed through unmodified; XZR semantics belong to the datapath.

Test Plan:
- Assert rst 2 cycles with strobes forced elsewhere -> all outputs at defaults, imem_addr = 0, halted = 0, illegal = 0.
- ADDI X1,X31,#5 (0x910017E1) -> EXEC cycle 3: SA = 31, DA = 1, B_sel = 1, k = 5, FS = 01000, alu_en = W_reg = 1; next imem_addr = 4.
- SUB X3,X1,X2 (0xCB020023) -> EXEC: FS = 01001, c_out = 1, SA = 1, SB = 2, DA = 3, B_sel = 0.
- STUR X2,[X1,#8] with f = 0x10 in MEM_ADDR -> addr = 0x10 next cycle; MEM_ST: SB = 2, B_en = W_ram = 1; only one bus enable high.
- CBZ X4,#-2 at pc = 0x20:
  - stat = 4'b0001 -> next pc = 0x18.
  - stat = 4'b0000 -> next pc = 0x24.
- Instruction 0xFFFFFFFF -> HALT: halted = 1, illegal = 1, pc frozen for 10 cycles; rst clears both flags.
